wb_stage_skid: RTL and testbench

// - Parametrised writeback pipeline stage: registers instruction and PC between memory and writeback.
// - Decodes the destination register and opcode for the register-file write and hazard logic.
// - Adds valid/ready handshake, a 2-entry skid buffer for back-pressure, flush, and a saturating bubble counter.

---
 rtl/pipe_pkg.sv | 25 ++
 rtl/wb_stage_skid_if.sv | 37 +++
 rtl/idecoder.sv | 26 ++
 rtl/pipe_skid_buf.sv | 96 +++++++++
 rtl/wb_stage_skid.sv | 95 +++++++++
 tb/tb_wb_stage_skid.sv | 245 ++++++++++++++++++++++++
 6 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the writeback pipeline stage.
//   NOP_INSTR     : instruction presented whenever no valid entry is held
//   INSTR_W_DEF   : default instruction width
//   PC_W_DEF      : default PC width
//   pipe_entry_t  : one pipeline entry {instr, pc} at the default widths
//   buf_state_e   : occupancy state of the head/skid buffer
package pipe_pkg;

    localparam int          INSTR_W_DEF = 32;
    localparam int          PC_W_DEF    = 7;
    localparam logic [31:0] NOP_INSTR   = 32'hE320F000;

    typedef struct packed {
        logic [INSTR_W_DEF-1:0] instr;
        logic [PC_W_DEF-1:0]    pc;
    } pipe_entry_t;

    // EMPTY: nothing held; HEAD: head only; FULL: head and skid both held.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_HEAD  = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

endpackage

// File: rtl/wb_stage_skid_if.sv
// Handshake/bus bundle between the memory stage, the writeback stage
// register and the writeback consumer.
//   master : upstream producer + downstream consumer (drives in_*, out_ready)
//   slave  : the stage itself (drives in_ready, out_*, rt, opcode)
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1; once valid is raised the payload is held stable until it
// transfers (or the stage is flushed/reset); ready never depends
// combinationally on the same-side valid.
interface wb_stage_skid_if
    import pipe_pkg::*;
#(
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int PC_W    = PC_W_DEF
);

    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] instr_in;
    logic [PC_W-1:0]    pc_in;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] instr_out;
    logic [PC_W-1:0]    pc_out;
    logic [3:0]         rt;
    logic [6:0]         opcode;

    modport master (
        output in_valid, instr_in, pc_in, out_ready,
        input  in_ready, out_valid, instr_out, pc_out, rt, opcode
    );

    modport slave (
        input  in_valid, instr_in, pc_in, out_ready,
        output in_ready, out_valid, instr_out, pc_out, rt, opcode
    );

endinterface

// File: rtl/idecoder.sv
// Field decoder for a 32-bit data-processing style instruction.
//   instr     in  32  instruction word
//   cond      out 4   condition field      [31:28]
//   opcode    out 7   opcode field         [27:21]
//   set_flags out 1   flag-update bit      [20]
//   rn        out 4   first source reg     [19:16]
//   rt        out 4   destination register [15:12]
//   operand2  out 12  second operand       [11:0]
module idecoder (
    input  logic [31:0] instr,
    output logic [3:0]  cond,
    output logic [6:0]  opcode,
    output logic        set_flags,
    output logic [3:0]  rn,
    output logic [3:0]  rt,
    output logic [11:0] operand2
);

    assign cond      = instr[31:28];
    assign opcode    = instr[27:21];
    assign set_flags = instr[20];
    assign rn        = instr[19:16];
    assign rt        = instr[15:12];
    assign operand2  = instr[11:0];

endmodule

// File: rtl/pipe_skid_buf.sv
// Two-entry head/skid buffer with valid/ready handshake and flush.
//   clk, rst   clock, synchronous active-high reset
//   flush      discard both held entries (same-cycle input dropped)
//   in_valid / in_ready / in_data     upstream side
//   out_valid / out_ready / out_data  downstream side (out_data = head)
//   state_dbg  current occupancy state
// in_ready is a pure function of the registered state, so there is no
// combinational path from out_ready to in_ready.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter type    entry_t    = pipe_entry_t,
    parameter entry_t IDLE_ENTRY = '0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       in_valid,
    output logic       in_ready,
    input  entry_t     in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output entry_t     out_data,
    output buf_state_e state_dbg
);

    buf_state_e state_q, state_d;
    entry_t     head_q, head_d;
    entry_t     skid_q, skid_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BUF_EMPTY;
            head_q  <= IDLE_ENTRY;
            skid_q  <= IDLE_ENTRY;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = BUF_EMPTY;
            head_d  = IDLE_ENTRY;
            skid_d  = IDLE_ENTRY;
        end else begin
            case (state_q)
                BUF_EMPTY: begin
                    if (in_valid) begin
                        head_d  = in_data;
                        state_d = BUF_HEAD;
                    end
                end
                BUF_HEAD: begin
                    if (out_ready) begin
                        // Head leaves; a same-cycle input replaces it directly.
                        if (in_valid) begin
                            head_d = in_data;
                        end else begin
                            head_d  = IDLE_ENTRY;
                            state_d = BUF_EMPTY;
                        end
                    end else if (in_valid) begin
                        // Head is stalled: park the new entry in the skid slot.
                        skid_d  = in_data;
                        state_d = BUF_FULL;
                    end
                end
                BUF_FULL: begin
                    // in_ready is 0 here, so only the drain side can move.
                    if (out_ready) begin
                        head_d  = skid_q;
                        skid_d  = IDLE_ENTRY;
                        state_d = BUF_HEAD;
                    end
                end
                default: begin
                    state_d = BUF_EMPTY;
                    head_d  = IDLE_ENTRY;
                    skid_d  = IDLE_ENTRY;
                end
            endcase
        end
    end

    assign in_ready  = (state_q != BUF_FULL);
    assign out_valid = (state_q != BUF_EMPTY);
    assign out_data  = head_q;
    assign state_dbg = state_q;

endmodule

// File: rtl/wb_stage_skid.sv
// Writeback pipeline stage: registers {instr, pc} between memory and
// writeback through a two-entry skid buffer, decodes rt/opcode from the
// presented instruction, and counts bubble cycles.
//   clk, rst    clock, synchronous active-high reset
//   flush       discard all held entries
//   bus         wb_stage_skid_if slave: in_valid/in_ready/instr_in/pc_in,
//               out_valid/out_ready/instr_out/pc_out, rt, opcode
//   bubble_cnt  cycles with out_valid=0 since reset, saturating
module wb_stage_skid
    import pipe_pkg::*;
#(
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int PC_W    = PC_W_DEF,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    wb_stage_skid_if.slave     bus,
    output logic [CNT_W-1:0]   bubble_cnt
);

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } entry_t;

    localparam logic [INSTR_W-1:0] NOP_W      = INSTR_W'(NOP_INSTR);
    localparam entry_t             IDLE_ENTRY = '{instr: NOP_W, pc: '0};
    localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

    entry_t     in_entry;
    entry_t     head_entry;
    logic       head_valid;
    buf_state_e buf_state_unused;

    assign in_entry = '{instr: bus.instr_in, pc: bus.pc_in};

    pipe_skid_buf #(
        .entry_t    (entry_t),
        .IDLE_ENTRY (IDLE_ENTRY)
    ) u_skid_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (in_entry),
        .out_valid (head_valid),
        .out_ready (bus.out_ready),
        .out_data  (head_entry),
        .state_dbg (buf_state_unused)
    );

    // An empty stage presents NOP/0 so the decoder sees a harmless instruction.
    assign bus.out_valid = head_valid;
    assign bus.instr_out = head_valid ? head_entry.instr : NOP_W;
    assign bus.pc_out    = head_valid ? head_entry.pc : '0;

    logic [3:0]  dec_cond_unused;
    logic        dec_s_unused;
    logic [3:0]  dec_rn_unused;
    logic [11:0] dec_op2_unused;

    idecoder u_idecoder (
        .instr     (32'(bus.instr_out)),
        .cond      (dec_cond_unused),
        .opcode    (bus.opcode),
        .set_flags (dec_s_unused),
        .rn        (dec_rn_unused),
        .rt        (bus.rt),
        .operand2  (dec_op2_unused)
    );

    // Bubble counter: flush does not clear it, only reset does.
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (!head_valid && (bubble_cnt_q != CNT_MAX)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_wb_stage_skid.sv
module tb_wb_stage_skid;

    localparam logic [31:0] NOP = 32'hE320F000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        flush;
    logic        rst_s;
    logic        flush_s;
    logic [15:0] bubble_cnt;
    logic [2:0]  bubble_s;

    wb_stage_skid_if #(.INSTR_W(32), .PC_W(7)) bus ();
    wb_stage_skid_if #(.INSTR_W(32), .PC_W(7)) bus_s ();

    wb_stage_skid #(.INSTR_W(32), .PC_W(7), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .bus        (bus),
        .bubble_cnt (bubble_cnt)
    );

    // Second instance with a tiny counter, kept idle, for saturation.
    wb_stage_skid #(.INSTR_W(32), .PC_W(7), .CNT_W(3)) dut_sat (
        .clk        (clk),
        .rst        (rst_s),
        .flush      (flush_s),
        .bus        (bus_s),
        .bubble_cnt (bubble_s)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: a FIFO of {instr, pc} holding at most two entries.
    logic [38:0] exp_q[$];
    int          exp_bub;
    int          exp_bub_s;

    // Advance one clock and apply the FIFO rules to the model.
    task automatic step();
        int n;
        bit in_f;
        bit out_f;
        logic [38:0] in_e;
        n     = exp_q.size();
        in_f  = bus.in_valid && (n < 2);
        out_f = bus.out_ready && (n > 0);
        in_e  = {bus.instr_in, bus.pc_in};
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            exp_bub = 0;
        end else begin
            if (n == 0 && exp_bub < 65535) exp_bub++;
            if (flush) begin
                exp_q.delete();
            end else begin
                if (out_f) void'(exp_q.pop_front());
                if (in_f) exp_q.push_back(in_e);
            end
        end
        if (rst_s) exp_bub_s = 0;
        else if (exp_bub_s < 7) exp_bub_s++;
        #1;
    endtask

    task automatic send(input logic [31:0] instr, input logic [6:0] pc);
        bus.in_valid = 1'b1;
        bus.instr_in = instr;
        bus.pc_in    = pc;
    endtask

    task automatic clear_stage();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rst_s = 1'b1; flush = 1'b0; flush_s = 1'b0;
        bus.in_valid = 1'b1; bus.out_ready = 1'b0; bus.instr_in = 32'h12345678; bus.pc_in = 7'd9;
        bus_s.in_valid = 1'b0; bus_s.out_ready = 1'b0; bus_s.instr_in = '0; bus_s.pc_in = '0;
        step();
        step();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", bus.out_valid); end
        total++; if (bus.instr_out !== NOP) begin bad++; $display("FAIL reset_instr got=%h want=%h", bus.instr_out, NOP); end
        total++; if (bus.pc_out !== 7'd0) begin bad++; $display("FAIL reset_pc got=%0d want=0", bus.pc_out); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", bus.in_ready); end
        total++; if (bubble_cnt !== 16'd0) begin bad++; $display("FAIL reset_bubble got=%0d want=0", bubble_cnt); end
        total++; if (bus.rt !== 4'hF) begin bad++; $display("FAIL reset_nop_rt got=%0h want=f", bus.rt); end
        total++; if (bus.opcode !== 7'h19) begin bad++; $display("FAIL reset_nop_opcode got=%0h want=19", bus.opcode); end
        rst = 1'b0; rst_s = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_pass_through();
        clear_stage();
        bus.out_ready = 1'b1;
        send(32'hE0812003, 7'd5);
        step();
        bus.in_valid = 1'b0;
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL pass_valid got=%0b want=1", bus.out_valid); end
        total++; if (bus.instr_out !== 32'hE0812003) begin bad++; $display("FAIL pass_instr got=%h want=e0812003", bus.instr_out); end
        total++; if (bus.pc_out !== 7'd5) begin bad++; $display("FAIL pass_pc got=%0d want=5", bus.pc_out); end
        total++; if (bus.rt !== 4'd2) begin bad++; $display("FAIL pass_rt got=%0d want=2", bus.rt); end
        total++; if (bus.opcode !== 7'd4) begin bad++; $display("FAIL pass_opcode got=%0d want=4", bus.opcode); end
        step();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL pass_drained got=%0b want=0", bus.out_valid); end
    endtask

    task automatic test_backpressure();
        logic [6:0] got[$];
        bit accepted;
        clear_stage();
        send(32'hAAAA0001, 7'd1); step();
        send(32'hBBBB0002, 7'd2); step();
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%0b want=0", bus.in_ready); end
        send(32'hCCCC0003, 7'd3); step(); step();
        total++; if (bus.pc_out !== 7'd1) begin bad++; $display("FAIL bp_head_held got=%0d want=1", bus.pc_out); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_still_full got=%0b want=0", bus.in_ready); end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (bus.out_valid) got.push_back(bus.pc_out);
            accepted = bus.in_valid && bus.in_ready;
            step();
            if (accepted) bus.in_valid = 1'b0;
            if (!bus.in_valid && !bus.out_valid) break;
        end
        total++; if (got.size() !== 3) begin bad++; $display("FAIL bp_drain_count got=%0d want=3", got.size()); end
        while (got.size() < 3) got.push_back(7'h7F);
        total++; if ({got[0], got[1], got[2]} !== {7'd1, 7'd2, 7'd3}) begin bad++; $display("FAIL bp_order got=%0d,%0d,%0d want=1,2,3", got[0], got[1], got[2]); end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_simultaneous();
        clear_stage();
        send(32'h0000A00A, 7'd10); step();
        send(32'h0000B00B, 7'd11); step();
        bus.out_ready = 1'b1;
        send(32'h0000C00C, 7'd12); step();
        total++; if (bus.pc_out !== 7'd11) begin bad++; $display("FAIL sim_head_b got=%0d want=11", bus.pc_out); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL sim_ready_reopen got=%0b want=1", bus.in_ready); end
        bus.out_ready = 1'b0;
        step();
        total++; if (bus.pc_out !== 7'd11) begin bad++; $display("FAIL sim_head_hold got=%0d want=11", bus.pc_out); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL sim_c_in_skid got=%0b want=0", bus.in_ready); end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        step();
        total++; if (bus.pc_out !== 7'd12 || bus.instr_out !== 32'h0000C00C) begin bad++; $display("FAIL sim_head_c got=%0d/%h want=12/0000c00c", bus.pc_out, bus.instr_out); end
        step();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL sim_empty got=%0b want=0", bus.out_valid); end
    endtask

    task automatic test_flush();
        clear_stage();
        send(32'h11110001, 7'd21); step();
        send(32'h22220002, 7'd22); step();
        send(32'h33330003, 7'd23);
        flush = 1'b1;
        step();
        flush = 1'b0; bus.in_valid = 1'b0;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%0b want=0", bus.out_valid); end
        total++; if (bus.instr_out !== NOP) begin bad++; $display("FAIL flush_instr got=%h want=%h", bus.instr_out, NOP); end
        total++; if (bus.pc_out !== 7'd0) begin bad++; $display("FAIL flush_pc got=%0d want=0", bus.pc_out); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready got=%0b want=1", bus.in_ready); end
        bus.out_ready = 1'b1;
        step();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_input_dropped got=%0b want=0", bus.out_valid); end
    endtask

    task automatic test_reset_mid();
        clear_stage();
        send(32'h44440004, 7'd31); step();
        send(32'h55550005, 7'd32); step();
        send(32'h66660006, 7'd33);
        rst = 1'b1; flush = 1'b1; bus.out_ready = 1'b1;
        step();
        rst = 1'b0; flush = 1'b0; bus.in_valid = 1'b0;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%0b want=0", bus.out_valid); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_in_ready got=%0b want=1", bus.in_ready); end
        total++; if (bubble_cnt !== 16'd0) begin bad++; $display("FAIL rstmid_bubble got=%0d want=0", bubble_cnt); end
        step();
        total++; if (bubble_cnt !== 16'd1) begin bad++; $display("FAIL rstmid_bubble_count got=%0d want=1", bubble_cnt); end
    endtask

    task automatic test_saturation();
        rst_s = 1'b1; step(); rst_s = 1'b0;
        repeat (10) step();
        total++; if (bubble_s !== 3'd7) begin bad++; $display("FAIL sat_reach got=%0d want=7", bubble_s); end
        repeat (3) step();
        total++; if (bubble_s !== 3'd7) begin bad++; $display("FAIL sat_hold got=%0d want=7", bubble_s); end
        rst_s = 1'b1; step(); rst_s = 1'b0;
        total++; if (bubble_s !== 3'd0) begin bad++; $display("FAIL sat_reset got=%0d want=0", bubble_s); end
        step(); step();
        total++; if (bubble_s !== 3'(exp_bub_s)) begin bad++; $display("FAIL sat_restart got=%0d want=%0d", bubble_s, exp_bub_s); end
    endtask

    task automatic test_random();
        logic [67:0] exp_v;
        logic [67:0] got_v;
        logic [31:0] e_instr;
        logic [6:0]  e_pc;
        int          n;
        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            flush         = ($urandom_range(0, 15) == 0);
            rst           = ($urandom_range(0, 63) == 0);
            bus.instr_in  = $urandom;
            bus.pc_in     = 7'($urandom_range(0, 127));
            step();
            n       = exp_q.size();
            e_instr = (n > 0) ? exp_q[0][38:7] : NOP;
            e_pc    = (n > 0) ? exp_q[0][6:0] : 7'd0;
            exp_v   = {(n > 0), e_instr, e_pc, (n < 2), e_instr[15:12], e_instr[27:21], 16'(exp_bub)};
            got_v   = {bus.out_valid, bus.instr_out, bus.pc_out, bus.in_ready, bus.rt, bus.opcode, bubble_cnt};
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL random_cycle_%0d got=%h want=%h", i, got_v, exp_v);
            end
        end
        rst = 1'b0; flush = 1'b0; bus.in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_backpressure();
        test_simultaneous();
        test_flush();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
